// File: rtl/keypad_operand_entry_pkg.sv
// Shared types and constants for the keypad operand entry path feeding the divider.
package divider_ui_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    KEY   = 2'd1,
    MULTI = 2'd2
  } frame_res_e;

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } deb_state_e;

  typedef struct packed {
    logic [7:0] dividend;
    logic [7:0] divisor;
  } operands_t;

  // Active-low column strobe for column index 0..3
  localparam logic [3:0] COL_STROBE [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic key_code_t key_code_of(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_operand_entry_if.sv
// Operand-side bus from keypad entry to the divider core.
interface keypad_operand_entry_if;
  import divider_ui_pkg::*;

  logic       key_valid;
  key_code_t  key_code;
  logic [1:0] entry_digits;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       start;

  modport master (output key_valid, key_code, entry_digits, dividend, divisor, start);
  modport slave  (input  key_valid, key_code, entry_digits, dividend, divisor, start);

endinterface

// File: rtl/keypad_operand_entry_scanner.sv
// 4x4 keypad column scanner with row synchronizer, per-frame decode and press/release debounce.
module keypad_scanner
  import divider_ui_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 2**18,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_row_n,
  output logic [3:0] o_col_n,
  output logic       o_key_valid,
  output key_code_t  o_key_code,
  output logic       o_accept_c,
  output key_code_t  o_accept_code_c
);

  localparam int unsigned     CNT_W     = $clog2(SCAN_DIV);
  localparam int unsigned     DB_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_col;
  logic [3:0]       r_col_n;
  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  logic [1:0]       r_frame_lows;
  key_code_t        r_frame_code;
  frame_res_e       r_prev_res;
  key_code_t        r_prev_code;
  logic [DB_W-1:0]  r_stable_cnt;
  deb_state_e       r_state;
  logic             r_key_valid;
  key_code_t        r_key_code;

  deb_state_e       w_state_next;
  logic             w_sample;
  logic             w_frame_end;
  logic [1:0]       w_col_next;
  logic [2:0]       w_col_lows;
  logic [1:0]       w_col_row;
  logic [2:0]       w_lows_sum;
  logic [1:0]       w_tot_lows;
  key_code_t        w_tot_code;
  frame_res_e       w_norm_res;
  key_code_t        w_norm_code;
  logic             w_same;
  logic [DB_W-1:0]  w_cnt_next;
  logic             w_stable;
  logic             w_accept;

  assign w_sample    = (r_scan_cnt == CNT_LAST);
  assign w_frame_end = w_sample && (r_col == 2'd3);
  assign w_col_next  = r_col + 2'd1;

  // Column timing; rows are sampled only on the last cycle of each column period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_col      <= '0;
      r_col_n    <= COL_STROBE[0];
    end else if (w_sample) begin
      r_scan_cnt <= '0;
      r_col      <= w_col_next;
      r_col_n    <= COL_STROBE[w_col_next];
    end else begin
      r_scan_cnt <= r_scan_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta <= 4'hF;
      r_row_sync <= 4'hF;
    end else begin
      r_row_meta <= i_row_n;
      r_row_sync <= r_row_meta;
    end
  end

  // Low rows in the active column; row r is on i_row_n[3-r]
  always_comb begin
    w_col_lows = '0;
    w_col_row  = '0;
    for (int r = 0; r < 4; r++) begin
      if (!r_row_sync[2'(3 - r)]) begin
        w_col_lows = w_col_lows + 3'd1;
        w_col_row  = 2'(r);
      end
    end
  end

  always_comb begin
    w_lows_sum  = {1'b0, r_frame_lows} + w_col_lows;
    w_tot_lows  = (w_lows_sum >= 3'd2) ? 2'd2 : w_lows_sum[1:0];
    w_tot_code  = (w_col_lows == 3'd1) ? key_code_of(w_col_row, r_col) : r_frame_code;
    // MULTI behaves exactly like NONE for debouncing
    w_norm_res  = (w_tot_lows == 2'd1) ? KEY : NONE;
    w_norm_code = (w_tot_lows == 2'd1) ? w_tot_code : '0;
    w_same      = (w_norm_res == r_prev_res) && (w_norm_code == r_prev_code);
    if (!w_same) begin
      w_cnt_next = DB_W'(1);
    end else if (r_stable_cnt < DB_TARGET) begin
      w_cnt_next = r_stable_cnt + DB_W'(1);
    end else begin
      w_cnt_next = r_stable_cnt;
    end
    w_stable = (w_cnt_next >= DB_TARGET);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_lows <= '0;
      r_frame_code <= '0;
      r_prev_res   <= NONE;
      r_prev_code  <= '0;
      r_stable_cnt <= '0;
    end else if (w_frame_end) begin
      r_frame_lows <= '0;
      r_frame_code <= '0;
      r_prev_res   <= w_norm_res;
      r_prev_code  <= w_norm_code;
      r_stable_cnt <= w_cnt_next;
    end else if (w_sample) begin
      r_frame_lows <= w_tot_lows;
      r_frame_code <= w_tot_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RELEASED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Debounce decisions happen once per frame, at the column 3 -> 0 boundary
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        RELEASED: begin
          if ((w_norm_res == KEY) && w_stable) begin
            w_state_next = PRESSED;
            w_accept     = 1'b1;
          end
        end
        PRESSED: begin
          if ((w_norm_res == NONE) && w_stable) begin
            w_state_next = RELEASED;
          end
        end
        default: w_state_next = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_key_code <= w_norm_code;
      end
    end
  end

  assign o_col_n         = r_col_n;
  assign o_key_valid     = r_key_valid;
  assign o_key_code      = r_key_code;
  assign o_accept_c      = w_accept;
  assign o_accept_code_c = w_norm_code;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad-to-divider operand entry: four accepted hex digits form dividend:divisor, then start.
module keypad_operand_entry
  import divider_ui_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 2**18,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic                   clock_100Mhz,
  input  logic                   reset_n,
  output logic [3:0]             Col_Activate,
  input  logic [3:0]             Row_in,
  keypad_operand_entry_if.master op_if
);

  logic       w_key_valid;
  key_code_t  w_key_code;
  logic       w_accept;
  key_code_t  w_accept_code;
  logic [15:0] w_sr_next;

  logic [15:0] r_sr;
  logic [1:0]  r_digits;
  operands_t   r_ops;
  logic        r_start;

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk             (clock_100Mhz),
    .rst_n           (reset_n),
    .i_row_n         (Row_in),
    .o_col_n         (Col_Activate),
    .o_key_valid     (w_key_valid),
    .o_key_code      (w_key_code),
    .o_accept_c      (w_accept),
    .o_accept_code_c (w_accept_code)
  );

  assign w_sr_next = {r_sr[11:0], w_accept_code};

  // Acts on the scanner's accept strobe so start/operands line up with key_valid
  always_ff @(posedge clock_100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      r_sr     <= '0;
      r_digits <= '0;
      r_ops    <= '0;
      r_start  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_accept) begin
        r_sr     <= w_sr_next;
        r_digits <= r_digits + 2'd1;
        if (r_digits == 2'd3) begin
          r_ops.dividend <= w_sr_next[15:8];
          r_ops.divisor  <= w_sr_next[7:0];
          r_start        <= 1'b1;
        end
      end
    end
  end

  assign op_if.key_valid    = w_key_valid;
  assign op_if.key_code     = w_key_code;
  assign op_if.entry_digits = r_digits;
  assign op_if.dividend     = r_ops.dividend;
  assign op_if.divisor      = r_ops.divisor;
  assign op_if.start        = r_start;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed bench for keypad_operand_entry with a behavioural 4x4 keypad matrix.
module tb_keypad_operand_entry;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] keys  = '0;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  int n_pass = 0;
  int n_total = 0;
  int pulse_cnt = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  keypad_operand_entry_if u_if();

  keypad_operand_entry #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clock_100Mhz (clk),
    .reset_n      (rst_n),
    .Col_Activate (col_n),
    .Row_in       (row_n),
    .op_if        (u_if)
  );

  // Pressed key (r,c) pulls row r low while column c is strobed
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !col_n[3-c]) row_n[3-r] = 1'b0;
  end

  always @(posedge clk) begin
    #2;
    if (rst_n === 1'b1) begin
      if (u_if.key_valid === 1'b1) pulse_cnt++;
      if (u_if.start === 1'b1) start_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic press_key(input int k, output logic ok, output logic [1:0] dg,
                           output logic st, output logic [7:0] dvd, output logic [7:0] dvs);
    ok = 1'b0; dg = '0; st = 1'b0; dvd = '0; dvs = '0;
    keys[k] = 1'b1;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (u_if.key_valid === 1'b1) begin
        ok = 1'b1; dg = u_if.entry_digits; st = u_if.start;
        dvd = u_if.dividend; dvs = u_if.divisor;
      end
    end
    keys[k] = 1'b0;
    repeat (48) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    int base;
    do_reset();
    base = pulse_cnt;
    n_total++; if (col_n !== 4'b0111) $display("FAIL reset_col: got %b want 0111", col_n); else n_pass++;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) begin
        n_total++; if (u_if.key_valid !== 1'b0) $display("FAIL reset_key_valid: got %b want 0", u_if.key_valid); else n_pass++;
        n_total++; if (u_if.key_code !== 4'h0) $display("FAIL reset_key_code: got %h want 0", u_if.key_code); else n_pass++;
        n_total++; if (u_if.entry_digits !== 2'd0) $display("FAIL reset_digits: got %0d want 0", u_if.entry_digits); else n_pass++;
        n_total++; if (u_if.dividend !== 8'h00) $display("FAIL reset_dividend: got %h want 00", u_if.dividend); else n_pass++;
        n_total++; if (u_if.divisor !== 8'h00) $display("FAIL reset_divisor: got %h want 00", u_if.divisor); else n_pass++;
        n_total++; if (u_if.start !== 1'b0) $display("FAIL reset_start: got %b want 0", u_if.start); else n_pass++;
      end
      if (n % 4 == 2) begin
        n_total++;
        if (col_n !== exp_col[(n/4)%4]) $display("FAIL scan_col_%0d: got %b want %b", n, col_n, exp_col[(n/4)%4]);
        else n_pass++;
      end
    end
    repeat (40) @(negedge clk);
    n_total++; if (pulse_cnt - base != 0) $display("FAIL idle_pulses: got %0d want 0", pulse_cnt - base); else n_pass++;
  endtask

  task automatic test_single_key();
    int base, lat;
    logic found;
    do_reset();
    base = pulse_cnt; found = 1'b0; lat = 0;
    keys[6] = 1'b1;
    for (int n = 1; n <= 100 && !found; n++) begin
      @(negedge clk);
      if (u_if.key_valid === 1'b1) begin found = 1'b1; lat = n; end
    end
    n_total++; if (lat != 32) $display("FAIL accept_latency: got %0d want 32", lat); else n_pass++;
    n_total++; if (u_if.key_code !== 4'h6) $display("FAIL key_code: got %h want 6", u_if.key_code); else n_pass++;
    repeat (48) @(negedge clk);
    n_total++; if (pulse_cnt - base != 1) $display("FAIL no_repeat: got %0d pulses want 1", pulse_cnt - base); else n_pass++;
    n_total++; if (u_if.key_code !== 4'h6) $display("FAIL key_code_held: got %h want 6", u_if.key_code); else n_pass++;
    keys[6] = 1'b0;
    repeat (48) @(negedge clk);
    keys[6] = 1'b1; found = 1'b0;
    for (int n = 1; n <= 100 && !found; n++) begin
      @(negedge clk);
      if (u_if.key_valid === 1'b1) found = 1'b1;
    end
    n_total++; if (found !== 1'b1) $display("FAIL repress_timeout: got %b want 1", found); else n_pass++;
    keys[6] = 1'b0;
    repeat (8) @(negedge clk);
    n_total++; if (pulse_cnt - base != 2) $display("FAIL repress_count: got %0d want 2", pulse_cnt - base); else n_pass++;
  endtask

  task automatic test_operands();
    int codes [4] = '{12, 8, 0, 5};
    logic [1:0] exp_dg [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic ok, st;
    logic [1:0] dg;
    logic [7:0] dvd, dvs;
    int base;
    do_reset();
    base = start_cnt;
    for (int i = 0; i < 4; i++) begin
      press_key(codes[i], ok, dg, st, dvd, dvs);
      n_total++; if (ok !== 1'b1) $display("FAIL op_press_%0d: got %b want 1", i, ok); else n_pass++;
      n_total++; if (dg !== exp_dg[i]) $display("FAIL op_digits_%0d: got %0d want %0d", i, dg, exp_dg[i]); else n_pass++;
      n_total++; if (st !== (i == 3)) $display("FAIL op_start_%0d: got %b want %b", i, st, (i == 3)); else n_pass++;
      if (i < 3) begin
        n_total++; if (dvd !== 8'h00) $display("FAIL op_partial_%0d: dividend got %h want 00", i, dvd); else n_pass++;
      end
    end
    n_total++; if (dvd !== 8'hC8) $display("FAIL op_dividend: got %h want C8", dvd); else n_pass++;
    n_total++; if (dvs !== 8'h05) $display("FAIL op_divisor: got %h want 05", dvs); else n_pass++;
    n_total++; if (start_cnt - base != 1) $display("FAIL op_start_count: got %0d want 1", start_cnt - base); else n_pass++;
    n_total++; if (u_if.dividend !== 8'hC8) $display("FAIL op_dividend_held: got %h want C8", u_if.dividend); else n_pass++;
  endtask

  task automatic test_two_keys();
    int base, lat;
    logic found;
    do_reset();
    base = pulse_cnt;
    keys[4] = 1'b1; keys[5] = 1'b1;
    repeat (64) @(negedge clk);
    n_total++; if (pulse_cnt - base != 0) $display("FAIL multi_pulses: got %0d want 0", pulse_cnt - base); else n_pass++;
    keys[5] = 1'b0; found = 1'b0; lat = 0;
    for (int n = 1; n <= 100 && !found; n++) begin
      @(negedge clk);
      if (u_if.key_valid === 1'b1) begin found = 1'b1; lat = n; end
    end
    n_total++; if (lat != 32) $display("FAIL multi_release_latency: got %0d want 32", lat); else n_pass++;
    n_total++; if (u_if.key_code !== 4'h4) $display("FAIL multi_release_code: got %h want 4", u_if.key_code); else n_pass++;
    keys = '0;
    repeat (48) @(negedge clk);
  endtask

  task automatic test_bounce();
    int base, first;
    do_reset();
    base = pulse_cnt; first = 0;
    keys[9] = 1'b1;
    for (int n = 1; n <= 130 && first == 0; n++) begin
      @(negedge clk);
      if (u_if.key_valid === 1'b1) first = n;
      keys[9] = (((n / 16) % 2) == 0) || (n >= 64);
    end
    n_total++; if (first != 96) $display("FAIL bounce_first_pulse: got %0d want 96", first); else n_pass++;
    n_total++; if (u_if.key_code !== 4'h9) $display("FAIL bounce_code: got %h want 9", u_if.key_code); else n_pass++;
    n_total++; if (pulse_cnt - base != 1) $display("FAIL bounce_count: got %0d want 1", pulse_cnt - base); else n_pass++;
    keys = '0;
    repeat (48) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int codes [4] = '{10, 11, 0, 3};
    logic ok, st;
    logic [1:0] dg;
    logic [7:0] dvd, dvs;
    do_reset();
    press_key(1, ok, dg, st, dvd, dvs);
    press_key(2, ok, dg, st, dvd, dvs);
    n_total++; if (dg !== 2'd2) $display("FAIL mid_pre_digits: got %0d want 2", dg); else n_pass++;
    do_reset();
    @(negedge clk);
    n_total++; if (u_if.entry_digits !== 2'd0) $display("FAIL mid_reset_digits: got %0d want 0", u_if.entry_digits); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      press_key(codes[i], ok, dg, st, dvd, dvs);
      if (i == 0) begin
        n_total++; if (dg !== 2'd1) $display("FAIL mid_first_digit: got %0d want 1", dg); else n_pass++;
      end
    end
    n_total++; if (ok !== 1'b1) $display("FAIL mid_last_press: got %b want 1", ok); else n_pass++;
    n_total++; if (st !== 1'b1) $display("FAIL mid_start: got %b want 1", st); else n_pass++;
    n_total++; if (dvd !== 8'hAB) $display("FAIL mid_dividend: got %h want AB", dvd); else n_pass++;
    n_total++; if (dvs !== 8'h03) $display("FAIL mid_divisor: got %h want 03", dvs); else n_pass++;
    n_total++; if (dg !== 2'd0) $display("FAIL mid_digits_wrap: got %0d want 0", dg); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_operands();
    test_two_keys();
    test_bounce();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
